// File: rtl/cim_pkg.sv
// -----------------------------------------------------------------------------
// cim_pkg
// Shared widths and the compute-FSM state type for the CIM sequencer slice.
//   A_W  : CIM write-address width
//   D_W  : CIM row-data width
//   X_W  : activation vector width
//   N_W  : CIM result width
//   cfsm_t : compute FSM states (C_IDLE -> C_START -> C_WAIT -> C_RES)
// -----------------------------------------------------------------------------
package cim_pkg;

    localparam int A_W = 8;
    localparam int D_W = 24;
    localparam int X_W = 192;
    localparam int N_W = 51;

    typedef enum logic [1:0] {
        C_IDLE,
        C_START,
        C_WAIT,
        C_RES
    } cfsm_t;

endpackage

// File: rtl/cim_seq_wdog.sv
// -----------------------------------------------------------------------------
// cim_seq_wdog
// Watchdog counter for the compute wait phase. Only instantiated by
// cim_seq_ctrl when CIM_SEQ_TIMEOUT_EN is defined.
// Ports:
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   clear    in   return the count to zero
//   enable   in   count one cycle
//   expired  out  high during the TIMEOUT_CYC-th enabled cycle
// -----------------------------------------------------------------------------
module cim_seq_wdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // First enabled cycle sees cnt=0, so the TIMEOUT_CYC-th sees TIMEOUT_CYC-1.
    assign expired = (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cim_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cim_seq_ctrl
// Sequencer in front of the CIM top. Weight bursts stream into the shadow
// bank while compute jobs run on the active bank; a completed burst is
// swapped in (cima toggles) once the compute FSM is idle.
// Optional feature macro: CIM_SEQ_TIMEOUT_EN adds a watchdog on the wait
// phase that aborts a job with res_err=1, res_data=0 after TIMEOUT_CYC cycles.
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   wl_valid/wl_ready/wl_addr/wl_data/wl_last   weight-load beats
//   job_valid/job_ready/job_xin/job_inw/job_ww  compute jobs
//   res_valid/res_ready/res_data/res_err        results
//   cima, WA, D, start, inwidth, wwidth, xin0   drive to CIM top
//   nout, st                                    result from CIM top
// -----------------------------------------------------------------------------
module cim_seq_ctrl
    import cim_pkg::*;
#(
    parameter logic [A_W-1:0] PARK_ADDR = 8'hFF
`ifdef CIM_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           wl_valid,
    output logic           wl_ready,
    input  logic [A_W-1:0] wl_addr,
    input  logic [D_W-1:0] wl_data,
    input  logic           wl_last,
    input  logic           job_valid,
    output logic           job_ready,
    input  logic [X_W-1:0] job_xin,
    input  logic           job_inw,
    input  logic           job_ww,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N_W-1:0] res_data,
    output logic           res_err,
    output logic           cima,
    output logic [A_W-1:0] WA,
    output logic [D_W-1:0] D,
    output logic           start,
    output logic           inwidth,
    output logic           wwidth,
    output logic [X_W-1:0] xin0,
    input  logic [N_W-1:0] nout,
    input  logic           st
);

    cfsm_t cfsm, cfsm_nxt;

    logic active_ok;    // active bank holds a complete weight set
    logic shadow_full;  // shadow bank holds a complete burst awaiting swap
    logic in_burst;     // a burst is partially written into the shadow bank
    logic swap_now;
    logic wl_fire;
    logic job_fire;
    logic timeout;

    // A swap toggles cima, so it must not land between beats of one burst.
    assign swap_now  = (cfsm == C_IDLE) && shadow_full && !in_burst;
    assign wl_ready  = !shadow_full && !swap_now;
    assign wl_fire   = wl_valid && wl_ready;
    assign job_ready = (cfsm == C_IDLE) && active_ok && !swap_now;
    assign job_fire  = job_valid && job_ready;

`ifdef CIM_SEQ_TIMEOUT_EN
    logic wdog_expired;

    cim_seq_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (cfsm != C_WAIT),
        .enable (cfsm == C_WAIT),
        .expired(wdog_expired)
    );

    // st arriving in the expiry cycle still wins; anything later is ignored.
    assign timeout = (cfsm == C_WAIT) && wdog_expired && !st;
`else
    assign timeout = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cfsm <= C_IDLE;
        else       cfsm <= cfsm_nxt;
    end

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        cfsm_nxt = cfsm;
        start    = 1'b0;
        case (cfsm)
            C_IDLE:  if (job_fire) cfsm_nxt = C_START;
            C_START: begin
                start    = 1'b1;
                cfsm_nxt = C_WAIT;
            end
            C_WAIT:  if (st || timeout) cfsm_nxt = C_RES;
            C_RES:   if (res_ready) cfsm_nxt = C_IDLE;
            default: cfsm_nxt = C_IDLE;
        endcase
    end

    // ------------------------------------------------- load path and banks
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            WA          <= PARK_ADDR;
            D           <= '0;
            cima        <= 1'b0;
            active_ok   <= 1'b0;
            shadow_full <= 1'b0;
            in_burst    <= 1'b0;
        end else begin
            if (wl_fire) begin
                WA <= wl_addr;
                D  <= wl_data;
                if (wl_last) begin
                    in_burst    <= 1'b0;
                    shadow_full <= 1'b1;
                end else begin
                    in_burst <= 1'b1;
                end
            end else begin
                // Park on a row that is never loaded so idle cycles write nothing useful.
                WA <= PARK_ADDR;
                D  <= '0;
            end
            // wl_ready is low while shadow_full, so this never collides with wl_fire.
            if (swap_now) begin
                cima        <= ~cima;
                active_ok   <= 1'b1;
                shadow_full <= 1'b0;
            end
        end
    end

    // ----------------------------------------------- job latch and result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xin0      <= '0;
            inwidth   <= 1'b0;
            wwidth    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (job_fire) begin
                xin0    <= job_xin;
                inwidth <= job_inw;
                wwidth  <= job_ww;
            end
            if (cfsm == C_WAIT && st) begin
                res_data  <= nout;
                res_valid <= 1'b1;
            end else if (timeout) begin
                res_data  <= '0;
                res_valid <= 1'b1;
            end else if (cfsm == C_RES && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef CIM_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_err <= 1'b0;
        end else if (cfsm == C_WAIT && st) begin
            res_err <= 1'b0;
        end else if (timeout) begin
            res_err <= 1'b1;
        end
    end
`else
    assign res_err = 1'b0;
`endif

endmodule
